ps2_host_tx: RTL

- Host-to-device PS/2 transmitter; the send path beside the existing PS/2 receive decoder in the user project.
- Takes one command byte over a valid/ready handshake and runs the host request-to-send sequence: clock inhibit, start bit, data, parity, stop, device ACK.
- Drives the open-collector PS/2 lines through active-high pull-low enables; the top level maps these to uio_out/uio_oe.

---
 rtl/ps2_host_tx.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, request-to-send, 11-bit frame, device ACK.
// Define PS2_TX_RETRY_EN to retry a failed byte once before reporting tx_err.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 1000,
   parameter int RTS_CYCLES     = 16,
   parameter int TIMEOUT_CYCLES = 20000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       tx_done,
   output logic       tx_err,
   output logic [2:0] dbg_state
);

   localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
   localparam int RTS_W = (RTS_CYCLES > 1) ? $clog2(RTS_CYCLES) : 1;
   localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
   localparam logic [RTS_W-1:0] RTS_LAST = RTS_W'(RTS_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_INHIBIT   = 3'd1;
   localparam logic [2:0] S_RTS       = 3'd2;
   localparam logic [2:0] S_SHIFT     = 3'd3;
   localparam logic [2:0] S_ACK       = 3'd4;
   localparam logic [2:0] S_WAIT_IDLE = 3'd5;
`ifdef PS2_TX_RETRY_EN
   localparam logic [2:0] S_GAP       = 3'd6;
`endif

   logic [2:0]       r_state;
   logic [7:0]       r_byte;
   logic             r_parity;
   logic [INH_W-1:0] r_inh_cnt;
   logic [RTS_W-1:0] r_rts_cnt;
   logic [TO_W-1:0]  r_to_cnt;
   logic [3:0]       r_bit_cnt;
   logic             r_clk_oe;
   logic             r_data_oe;
   logic             r_done;
   logic             r_err;
   logic             r_clk_s1, r_clk_s2, r_clk_d;
   logic             r_dat_s1, r_dat_s2;
`ifdef PS2_TX_RETRY_EN
   logic             r_retried;
`endif

   logic w_accept;
   logic w_clk_fall;
   logic w_bus_idle;
   logic w_to_busy;
   logic w_nack;
   logic w_timeout;
   logic w_fail;

   // Handshake: tx_ready is high in IDLE except during a done/err pulse cycle;
   // a byte is taken at the posedge where tx_valid & tx_ready.
   assign tx_ready   = (r_state == S_IDLE) & ~r_done & ~r_err;
   assign w_accept   = tx_valid & tx_ready;
   assign w_clk_fall = r_clk_d & ~r_clk_s2;
   assign w_bus_idle = r_clk_s2 & r_dat_s2;
   assign w_to_busy  = (r_state == S_SHIFT) | (r_state == S_ACK) | (r_state == S_WAIT_IDLE);
   assign w_nack     = (r_state == S_ACK) & w_clk_fall & r_dat_s2;
   // A falling edge or a finished bus-idle wait both beat the timeout in the same cycle.
   assign w_timeout  = w_to_busy & ~w_clk_fall & (r_to_cnt == TO_LAST)
                       & ~((r_state == S_WAIT_IDLE) & w_bus_idle);
   assign w_fail     = w_nack | w_timeout;

   assign ps2_clk_oe  = r_clk_oe;
   assign ps2_data_oe = r_data_oe;
   assign tx_done     = r_done;
   assign tx_err      = r_err;
   assign dbg_state   = r_state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_byte    <= '0;
         r_parity  <= 1'b0;
         r_inh_cnt <= '0;
         r_rts_cnt <= '0;
         r_to_cnt  <= '0;
         r_bit_cnt <= '0;
         r_clk_oe  <= 1'b0;
         r_data_oe <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_clk_s1  <= 1'b1;
         r_clk_s2  <= 1'b1;
         r_clk_d   <= 1'b1;
         r_dat_s1  <= 1'b1;
         r_dat_s2  <= 1'b1;
`ifdef PS2_TX_RETRY_EN
         r_retried <= 1'b0;
`endif
      end else begin
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_clk_s1 <= ps2_clk_in;
         r_clk_s2 <= r_clk_s1;
         r_clk_d  <= r_clk_s2;
         r_dat_s1 <= ps2_data_in;
         r_dat_s2 <= r_dat_s1;
         if (w_fail) begin
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_to_cnt  <= '0;
`ifdef PS2_TX_RETRY_EN
            if (!r_retried) begin
               r_retried <= 1'b1;
               r_state   <= S_GAP;
            end else begin
               r_err   <= 1'b1;
               r_state <= S_IDLE;
            end
`else
            r_err   <= 1'b1;
            r_state <= S_IDLE;
`endif
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_accept) begin
                     r_byte    <= tx_data;
                     r_parity  <= ~^tx_data;
                     r_inh_cnt <= '0;
                     r_clk_oe  <= 1'b1;
                     r_data_oe <= 1'b0;
                     r_state   <= S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
                     r_retried <= 1'b0;
`endif
                  end
               end
               S_INHIBIT: begin
                  if (r_inh_cnt == INH_LAST) begin
                     r_inh_cnt <= '0;
                     r_rts_cnt <= '0;
                     r_data_oe <= 1'b1;
                     r_state   <= S_RTS;
                  end else begin
                     r_inh_cnt <= r_inh_cnt + 1'b1;
                  end
               end
               S_RTS: begin
                  if (r_rts_cnt == RTS_LAST) begin
                     r_rts_cnt <= '0;
                     r_clk_oe  <= 1'b0;
                     r_bit_cnt <= '0;
                     r_to_cnt  <= '0;
                     r_state   <= S_SHIFT;
                  end else begin
                     r_rts_cnt <= r_rts_cnt + 1'b1;
                  end
               end
               S_SHIFT: begin
                  if (w_clk_fall) begin
                     r_to_cnt  <= '0;
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                     // Line level is the inverse of the pull-low enable: data LSB first, then odd parity, then stop.
                     if (r_bit_cnt < 4'd8) begin
                        r_data_oe <= ~r_byte[r_bit_cnt[2:0]];
                     end else if (r_bit_cnt == 4'd8) begin
                        r_data_oe <= ~r_parity;
                     end else begin
                        r_data_oe <= 1'b0;
                        r_state   <= S_ACK;
                     end
                  end else if (r_to_cnt != TO_LAST) begin
                     r_to_cnt <= r_to_cnt + 1'b1;
                  end
               end
               S_ACK: begin
                  if (w_clk_fall) begin
                     r_to_cnt <= '0;
                     r_state  <= S_WAIT_IDLE;
                  end else if (r_to_cnt != TO_LAST) begin
                     r_to_cnt <= r_to_cnt + 1'b1;
                  end
               end
               S_WAIT_IDLE: begin
                  if (w_bus_idle) begin
                     r_done   <= 1'b1;
                     r_to_cnt <= '0;
                     r_state  <= S_IDLE;
                  end else if (w_clk_fall) begin
                     r_to_cnt <= '0;
                  end else if (r_to_cnt != TO_LAST) begin
                     r_to_cnt <= r_to_cnt + 1'b1;
                  end
               end
`ifdef PS2_TX_RETRY_EN
               S_GAP: begin
                  r_inh_cnt <= '0;
                  r_clk_oe  <= 1'b1;
                  r_state   <= S_INHIBIT;
               end
`endif
               default: begin
                  r_clk_oe  <= 1'b0;
                  r_data_oe <= 1'b0;
                  r_state   <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule
